// File: rtl/sobel_grad_3x3.sv
// sobel_grad_3x3: three-stage Sobel magnitude/direction pipeline with per-frame peak and edge-count stats
module sobel_grad_3x3 #(
  parameter int MAG_SHIFT = 2,
  parameter int EDGE_TH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        eof_in,
  input  logic [7:0]  p0,
  input  logic [7:0]  p1,
  input  logic [7:0]  p2,
  input  logic [7:0]  p3,
  input  logic [7:0]  p4,
  input  logic [7:0]  p5,
  input  logic [7:0]  p6,
  input  logic [7:0]  p7,
  input  logic [7:0]  p8,
  output logic [7:0]  mag_out,
  output logic [1:0]  dir_out,
  output logic        valid_out,
  output logic        frame_done,
  output logic [7:0]  frame_max_out,
  output logic [15:0] frame_edges_out
);
  localparam logic [7:0] TH = 8'(EDGE_TH);
  logic [9:0] xp, xn, yp, yn, ax, ay;
  logic signed [10:0] gx_c, gy_c, s1_gx, s1_gy;
  logic [10:0] nx, ny, sh, s2_sum;
  logic [16:0] ax128, ay128, ax53, ay53;
  logic [1:0] dir_c, s2_dir;
  logic [7:0] mag_c, max_c, run_max;
  logic [15:0] cnt_c, run_cnt;
  logic s1_v, s1_e, s2_v, s2_e, edge_c;
  // p4 is the centre pixel and carries zero weight in both kernels
  logic unused_p4;
  assign unused_p4 = ^p4;
  assign xp = {2'b0, p2} + {1'b0, p5, 1'b0} + {2'b0, p8};
  assign xn = {2'b0, p0} + {1'b0, p3, 1'b0} + {2'b0, p6};
  assign yp = {2'b0, p6} + {1'b0, p7, 1'b0} + {2'b0, p8};
  assign yn = {2'b0, p0} + {1'b0, p1, 1'b0} + {2'b0, p2};
  assign gx_c = $signed({1'b0, xp}) - $signed({1'b0, xn});
  assign gy_c = $signed({1'b0, yp}) - $signed({1'b0, yn});
  assign nx = -s1_gx;
  assign ny = -s1_gy;
  assign ax = s1_gx[10] ? nx[9:0] : s1_gx[9:0];
  assign ay = s1_gy[10] ? ny[9:0] : s1_gy[9:0];
  // tan(22.5 deg) ~ 53/128; exact integer products decide the sector
  assign ax128 = {ax, 7'b0};
  assign ay128 = {ay, 7'b0};
  assign ax53 = {7'b0, ax} * 17'd53;
  assign ay53 = {7'b0, ay} * 17'd53;
  always_comb begin
    dir_c = (ax == 10'd0 && ay == 10'd0) ? 2'd0 :
            (ay128 < ax53) ? 2'd0 :
            (ay53 > ax128) ? 2'd2 :
            (s1_gx[10] == s1_gy[10]) ? 2'd1 : 2'd3;
  end
  assign sh = s2_sum >> MAG_SHIFT;
  assign mag_c = |sh[10:8] ? 8'hff : sh[7:0];
  assign edge_c = mag_c >= TH;
  assign max_c = mag_c > run_max ? mag_c : run_max;
  assign cnt_c = (edge_c && run_cnt != 16'hffff) ? run_cnt + 16'd1 : run_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_gx <= '0;
      s1_gy <= '0;
      s1_v <= 1'b0;
      s1_e <= 1'b0;
      s2_sum <= '0;
      s2_dir <= '0;
      s2_v <= 1'b0;
      s2_e <= 1'b0;
      mag_out <= '0;
      dir_out <= '0;
      valid_out <= 1'b0;
      frame_done <= 1'b0;
      frame_max_out <= '0;
      frame_edges_out <= '0;
      run_max <= '0;
      run_cnt <= '0;
    end else begin
      s1_gx <= gx_c;
      s1_gy <= gy_c;
      s1_v <= valid_in;
      s1_e <= valid_in & eof_in;
      s2_sum <= {1'b0, ax} + {1'b0, ay};
      s2_dir <= dir_c;
      s2_v <= s1_v;
      s2_e <= s1_e;
      mag_out <= mag_c;
      dir_out <= s2_dir;
      valid_out <= s2_v;
      frame_done <= s2_v & s2_e;
      if (s2_v && s2_e) begin
        frame_max_out <= max_c;
        frame_edges_out <= cnt_c;
        run_max <= '0;
        run_cnt <= '0;
      end else if (s2_v) begin
        run_max <= max_c;
        run_cnt <= cnt_c;
      end
    end
  end
endmodule

// File: tb/tb_sobel_grad_3x3.sv
// tb_sobel_grad_3x3: directed and randomized checks of sobel_grad_3x3 against a frame-level reference model
module tb_sobel_grad_3x3;
  localparam int MS = 2;
  localparam int TH = 64;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, eof_in = 1'b0;
  logic [7:0] w [9];
  logic [7:0] mag_out, frame_max_out;
  logic [1:0] dir_out;
  logic valid_out, frame_done;
  logic [15:0] frame_edges_out;
  typedef struct {bit v; bit e; int mag; int dir;} ent_t;
  ent_t q[$];
  int run_max, run_cnt, fmax, fedges, em, edr;
  bit ev, ed;
  int checks = 0, passed = 0;
  int pm [5] = '{0, 255, 100, 100, 100};
  int pd [5] = '{0, 0, 2, 1, 3};

  sobel_grad_3x3 #(.MAG_SHIFT(MS), .EDGE_TH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .eof_in(eof_in),
    .p0(w[0]), .p1(w[1]), .p2(w[2]), .p3(w[3]), .p4(w[4]),
    .p5(w[5]), .p6(w[6]), .p7(w[7]), .p8(w[8]),
    .mag_out(mag_out), .dir_out(dir_out), .valid_out(valid_out),
    .frame_done(frame_done), .frame_max_out(frame_max_out),
    .frame_edges_out(frame_edges_out));

  always #5 clk = ~clk;

  function automatic void ref_win(output int mag, output int dir);
    int gx, gy, ax, ay, s;
    gx = (int'(w[2]) + 2*int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2*int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[1]) + int'(w[2]));
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    s = (ax + ay) >> MS;
    mag = s > 255 ? 255 : s;
    if (ax == 0 && ay == 0) dir = 0;
    else if (128*ay < 53*ax) dir = 0;
    else if (53*ay > 128*ax) dir = 2;
    else if ((gx < 0) == (gy < 0)) dir = 1;
    else dir = 3;
  endfunction

  function automatic logic [35:0] obs();
    return {valid_out, valid_out ? mag_out : 8'd0, valid_out ? dir_out : 2'd0,
            frame_done, frame_max_out, frame_edges_out};
  endfunction

  function automatic logic [35:0] expv();
    return {ev, ev ? 8'(em) : 8'd0, ev ? 2'(edr) : 2'd0, ed, 8'(fmax), 16'(fedges)};
  endfunction

  task automatic model_reset();
    q.delete();
    run_max = 0; run_cnt = 0; fmax = 0; fedges = 0; ev = 0; ed = 0; em = 0; edr = 0;
  endtask

  task automatic pat(input int k);
    int c;
    c = $urandom_range(0, 255);
    for (int i = 0; i < 9; i++) w[i] = 8'd0;
    case (k)
      0: for (int i = 0; i < 9; i++) w[i] = 8'd77;
      1: begin w[2] = 8'd255; w[5] = 8'd255; w[8] = 8'd255; w[1] = 8'(c); w[4] = 8'(c); w[7] = 8'(c); end
      2: begin w[3] = 8'd50; w[4] = 8'd50; w[5] = 8'd50; w[6] = 8'd100; w[7] = 8'd100; w[8] = 8'd100; end
      3: w[8] = 8'd200;
      default: w[6] = 8'd200;
    endcase
  endtask

  // one clock of stimulus; the model yields what the outputs must show after this edge
  task automatic step(input bit v, input bit e);
    int m, d;
    ent_t o;
    valid_in = v;
    eof_in = e;
    ref_win(m, d);
    q.push_back('{v, e, m, d});
    @(posedge clk);
    #1;
    ev = 0;
    ed = 0;
    if (q.size() == 3) begin
      o = q.pop_front();
      ev = o.v; em = o.mag; edr = o.dir;
      if (o.v) begin
        if (o.mag > run_max) run_max = o.mag;
        if (o.mag >= TH && run_cnt < 65535) run_cnt++;
        if (o.e) begin
          fmax = run_max; fedges = run_cnt; ed = 1; run_max = 0; run_cnt = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    valid_in = 0;
    eof_in = 0;
    pat(0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs() !== 36'd0 || mag_out !== 8'd0 || dir_out !== 2'd0) $display("FAIL reset_state got=%h want=0", obs());
    else passed++;
    rst_n = 1;
  endtask

  task automatic test_frame_stats();
    int dc = 0;
    for (int k = 0; k < 4; k++) begin
      pat(k);
      step(1, k == 3);
      checks++;
      if (obs() !== expv()) $display("FAIL frame_stats_win got=%h want=%h", obs(), expv());
      else passed++;
      dc += int'(frame_done);
      step(0, 1);
      checks++;
      if (obs() !== expv()) $display("FAIL frame_stats_bubble got=%h want=%h", obs(), expv());
      else passed++;
      dc += int'(frame_done);
    end
    step(0, 0);
    checks++;
    if ({frame_done, frame_max_out, frame_edges_out} !== {1'b1, 8'd255, 16'd3})
      $display("FAIL frame_stats_first got=%b/%0d/%0d want=1/255/3", frame_done, frame_max_out, frame_edges_out);
    else passed++;
    dc += int'(frame_done);
    step(0, 0);
    checks++;
    if (dc !== 1 || frame_done !== 1'b0 || frame_max_out !== 8'd255) $display("FAIL frame_stats_pulses got=%0d want=1", dc);
    else passed++;
    pat(0);
    step(1, 1);
    step(0, 0);
    step(0, 0);
    checks++;
    if ({frame_done, frame_max_out, frame_edges_out} !== {1'b1, 8'd0, 16'd0} || obs() !== expv())
      $display("FAIL frame_stats_flat got=%b/%0d/%0d want=1/0/0", frame_done, frame_max_out, frame_edges_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int dc = 0;
    pat(1);
    step(1, 1);
    pat(2);
    step(1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      dc += int'(frame_done);
      checks++;
      if (obs() !== expv()) $display("FAIL back_to_back_cycle%0d got=%h want=%h", i, obs(), expv());
      else passed++;
    end
    checks++;
    if (dc !== 2 || frame_max_out !== 8'd100 || frame_edges_out !== 16'd1)
      $display("FAIL back_to_back_second got=%0d/%0d/%0d want=2/100/1", dc, frame_max_out, frame_edges_out);
    else passed++;
  endtask

  task automatic test_patterns();
    for (int k = 0; k < 5; k++) begin
      pat(k);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      checks++;
      if (valid_out !== 1'b1 || mag_out !== 8'(pm[k]) || dir_out !== 2'(pd[k]))
        $display("FAIL pattern%0d got=%b/%0d/%0d want=1/%0d/%0d", k, valid_out, mag_out, dir_out, pm[k], pd[k]);
      else passed++;
      checks++;
      if (obs() !== expv()) $display("FAIL pattern%0d_model got=%h want=%h", k, obs(), expv());
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit stepy;
      stepy = $urandom_range(0, 1) == 1;
      for (int i = 0; i < 9; i++)
        w[i] = stepy ? ($urandom_range(0, 1) == 1 ? 8'd255 : 8'd0) : 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      checks++;
      if (obs() !== expv()) $display("FAIL random_%0d got=%h want=%h", n, obs(), expv());
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    pat(1);
    for (int i = 0; i < 5; i++) step(1, 0);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (obs() !== 36'd0 || mag_out !== 8'd0 || dir_out !== 2'd0) $display("FAIL midreset_async got=%h want=0", obs());
    else passed++;
    valid_in = 0;
    eof_in = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      checks++;
      if (valid_out !== 1'b0 || obs() !== expv()) $display("FAIL midreset_drop%0d got=%h want=%h", i, obs(), expv());
      else passed++;
    end
    pat(0);
    step(1, 0);
    pat(2);
    step(1, 1);
    step(0, 0);
    step(0, 0);
    checks++;
    if ({frame_done, frame_max_out, frame_edges_out} !== {1'b1, 8'd100, 16'd1} || obs() !== expv())
      $display("FAIL midreset_stats got=%b/%0d/%0d want=1/100/1", frame_done, frame_max_out, frame_edges_out);
    else passed++;
  endtask

  task automatic test_saturation();
    pat(1);
    for (int i = 0; i < 65540; i++) step(1, i == 65539);
    step(0, 0);
    step(0, 0);
    checks++;
    if (frame_done !== 1'b1 || frame_edges_out !== 16'hffff || obs() !== expv())
      $display("FAIL edge_saturation got=%b/%0d want=1/65535", frame_done, frame_edges_out);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame_stats();
    test_back_to_back();
    test_patterns();
    test_random();
    test_reset_midframe();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
